// File: rtl/spi_cmd_initiator.sv
// SPI mode-0 master issuing header + payload command transactions.
// Every word shifted back on MISO is returned with its word index.
module spi_cmd_initiator #(
    parameter int word_bits = 16,
    parameter int CLK_DIV   = 2,
    parameter int GAP_CYC   = 8,
    parameter int LEN_BITS  = 4
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_header,
    input  logic [word_bits-9:0]  cmd_arg,
    input  logic [LEN_BITS-1:0]   cmd_len,
    input  logic [word_bits-1:0]  tx_word,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [word_bits-1:0]  rx_word,
    output logic                  rx_valid,
    output logic [LEN_BITS-1:0]   rx_idx,
    output logic                  done,
    output logic                  sck,
    output logic                  mosi,
    output logic                  cs_n,
    input  logic                  miso
);

    localparam int CW = $clog2(2 * CLK_DIV + GAP_CYC);
    localparam int BW = $clog2(word_bits);
    localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PH_HI    = CW'(CLK_DIV);
    localparam logic [CW-1:0] PH_END   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] GAP_MORE = CW'((GAP_CYC > 1) ? GAP_CYC - 2 : 0);
    localparam logic [BW-1:0] BIT_END  = BW'(word_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_FETCH, S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [LEN_BITS-1:0]    idx_q, idx_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [word_bits-1:0]   sh_q, sh_d;
    logic [word_bits-1:0]   rxs_q, rxs_d;
    logic [word_bits-1:0]   rx_word_q, rx_word_d;
    logic [LEN_BITS-1:0]    rx_idx_q, rx_idx_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   done_q, done_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic                   cs_n_q, cs_n_d;
    logic                   last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        idx_d       = idx_q;
        len_d       = len_q;
        sh_d        = sh_q;
        rxs_d       = rxs_q;
        rx_word_d   = rx_word_q;
        rx_idx_d    = rx_idx_q;
        rx_valid_d  = 1'b0;
        done_d      = 1'b0;
        cmd_ready_d = 1'b0;
        tx_ready    = 1'b0;
        last        = (idx_q == len_q);
        unique case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    len_d       = cmd_len;
                    idx_d       = '0;
                    sh_d        = {cmd_header, cmd_arg};
                    cnt_d       = '0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == PH_HI) begin
                    rxs_d = {rxs_q[word_bits-2:0], miso};
                end
                if (cnt_q == PH_END) begin
                    cnt_d = '0;
                    if (bit_q == BIT_END) begin
                        rx_word_d  = rxs_d;
                        rx_idx_d   = idx_q;
                        rx_valid_d = 1'b1;
                        // With a one-cycle gap the fetch cycle is the gap.
                        state_d = (!last && GAP_CYC == 1) ? S_FETCH : S_GAP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sh_d  = {sh_q[word_bits-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == (last ? GAP_LAST : GAP_MORE)) begin
                    cnt_d   = '0;
                    state_d = last ? S_HOLD : S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                if (tx_valid) begin
                    tx_ready = 1'b1;
                    sh_d     = tx_word;
                    idx_d    = idx_q + 1'b1;
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Pins are registered from the next-cycle view so they are glitch free.
        sck_d  = (state_d == S_SHIFT) && (cnt_d >= PH_HI);
        mosi_d = (state_d == S_SETUP || state_d == S_SHIFT) ?
                 sh_d[word_bits-1] : 1'b0;
        cs_n_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            sh_q        <= '0;
            rxs_q       <= '0;
            rx_word_q   <= '0;
            rx_idx_q    <= '0;
            rx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            sh_q        <= sh_d;
            rxs_q       <= rxs_d;
            rx_word_q   <= rx_word_d;
            rx_idx_q    <= rx_idx_d;
            rx_valid_q  <= rx_valid_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rx_word   = rx_word_q;
    assign rx_valid  = rx_valid_q;
    assign rx_idx    = rx_idx_q;
    assign done      = done_q;
    assign sck       = sck_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_cmd_initiator.sv
// Bench for spi_cmd_initiator: echo slave, transaction-level model, random commands.
// One compare process checks DUT outputs against the model every cycle.
module tb_spi_cmd_initiator;

    localparam int WB = 16;
    localparam int CD = 2;
    localparam int GC = 8;
    localparam int LB = 4;

    logic          CLK = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_header;
    logic [7:0]    cmd_arg;
    logic [LB-1:0] cmd_len;
    logic [WB-1:0] tx_word;
    logic          tx_valid;
    logic          tx_ready;
    logic [WB-1:0] rx_word;
    logic          rx_valid;
    logic [LB-1:0] rx_idx;
    logic          done;
    logic          sck;
    logic          mosi;
    logic          cs_n;
    logic          miso = 1'b0;

    spi_cmd_initiator #(
        .word_bits(WB), .CLK_DIV(CD), .GAP_CYC(GC), .LEN_BITS(LB)
    ) dut (
        .CLK(CLK), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_header(cmd_header), .cmd_arg(cmd_arg), .cmd_len(cmd_len),
        .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_idx(rx_idx),
        .done(done), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // stimulus-owned controls
    bit want_ones;
    bit want_cyc;
    bit tx_hold;
    bit rnd_hold;
    int tx_wr = 0;
    logic [WB-1:0] tx_src [0:255];

    // slave model: mode 0, MSB first, echoes the previous word of this frame
    logic [WB-1:0] s_out;
    logic [WB-1:0] s_rxs;
    int            s_bc;
    logic          s_pcs = 1'b1;
    logic          s_psck = 1'b0;
    int            slv_n = 0;
    logic [WB-1:0] slv_words [0:1023];

    // compare-process-owned model
    bit            active = 0;
    bit            ones = 0;
    bit            cyc_chk = 0;
    int            m_len;
    logic [WB-1:0] sent [$];
    int            nrx, ntx, nslv;
    int            low_cyc = 0;
    int            last_low = 0;
    int            n_done = 0;
    int            slv_seen = 0;
    bit            expect_rdy = 0;
    logic          c_psck = 1'b0;
    logic          c_pmosi = 1'b0;
    logic [WB-1:0] rx_log [0:15];

    always @(cs_n or sck) begin
        if (cs_n) begin
            s_bc = 0;
        end else if (s_pcs) begin
            s_bc  = 0;
            s_out = '0;
            s_rxs = '0;
            miso  = ones;
        end else if (sck && !s_psck) begin
            s_rxs = {s_rxs[WB-2:0], mosi};
            s_bc++;
            if (s_bc == WB) begin
                slv_words[slv_n % 1024] = s_rxs;
                slv_n++;
                s_out = s_rxs;
                s_bc  = 0;
            end
        end else if (!sck && s_psck) begin
            miso = ones ? 1'b1 : s_out[WB-1-s_bc];
        end
        s_pcs  = cs_n;
        s_psck = sck;
    end

    // payload source driver
    initial begin
        int  tx_rd;
        bit  hs;
        bit  hold;
        tx_rd = 0;
        tx_valid = 1'b0;
        tx_word = '0;
        forever begin
            @(negedge CLK);
            hs = tx_ready;
            @(posedge CLK);
            #1;
            if (!resetn) tx_rd = tx_wr;
            else if (hs) tx_rd++;
            hold = tx_hold || (rnd_hold && $urandom_range(0, 3) == 0);
            tx_valid = (tx_rd < tx_wr) && !hold && resetn;
            tx_word = tx_src[tx_rd % 256];
        end
    end

    // single compare process
    always @(negedge CLK) begin
        logic [31:0] exp;
        if (!resetn) begin
            active   = 0;
            slv_seen = slv_n;
            c_psck   = 1'b0;
        end else begin
            if (!cs_n) low_cyc++;
            if (sck && c_psck) chk("mosi_stable_sck_high", mosi, c_pmosi);
            if (sck) chk("cs_low_while_sck_high", cs_n, 0);
            if (!cs_n) chk("cmd_ready_busy", cmd_ready, 0);
            if (expect_rdy) begin
                chk("cmd_ready_after_done", cmd_ready, 1);
                expect_rdy = 0;
            end
            if (tx_ready) begin
                chk("tx_ready_allowed", active && ntx < m_len, 1);
                sent.push_back(tx_word);
                ntx++;
            end
            while (slv_seen < slv_n) begin
                exp = (active && nslv < sent.size()) ?
                      {16'h0, sent[nslv]} : 32'hDEADBEEF;
                chk("mosi_word", slv_words[slv_seen % 1024], exp);
                slv_seen++;
                nslv++;
            end
            if (rx_valid) begin
                if (!active) exp = 32'hDEADBEEF;
                else if (ones) exp = 32'h0000FFFF;
                else if (nrx == 0) exp = 32'h0;
                else exp = {16'h0, sent[nrx-1]};
                chk("rx_word", rx_word, exp);
                chk("rx_idx", rx_idx, nrx);
                if (nrx < 16) rx_log[nrx] = rx_word;
                nrx++;
            end
            if (done) begin
                chk("done_in_txn", active, 1);
                chk("done_cs_n_high", cs_n, 1);
                chk("rx_count", nrx, m_len + 1);
                chk("tx_ready_count", ntx, m_len);
                chk("slave_word_count", nslv, m_len + 1);
                if (cyc_chk)
                    chk("cs_low_cycles", low_cyc,
                        CD + (m_len + 1) * 2 * CD * WB + (m_len + 1) * GC + CD);
                last_low   = low_cyc;
                active     = 0;
                expect_rdy = 1;
                n_done++;
            end
            if (cmd_valid && cmd_ready) begin
                active  = 1;
                m_len   = cmd_len;
                sent.delete();
                sent.push_back({cmd_header, cmd_arg});
                nrx     = 0;
                ntx     = 0;
                nslv    = 0;
                low_cyc = 0;
                cyc_chk = want_cyc;
                ones    = want_ones;
            end
            c_psck  = sck;
            c_pmosi = mosi;
        end
    end

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) begin
            tx_src[tx_wr % 256] = WB'($urandom);
            tx_wr++;
        end
    endtask

    task automatic accept();
        bit hs;
        int n;
        n = 0;
        hs = 0;
        while (!hs && n < 200) begin
            @(negedge CLK);
            hs = cmd_ready;
            @(posedge CLK);
            #1;
            n++;
        end
        chk("cmd_accept", hs, 1);
    endtask

    task automatic run_cmd(input logic [7:0] h, input logic [7:0] a,
                           input logic [LB-1:0] l, input bit om,
                           input bit cm, input int npush);
        want_ones = om;
        want_cyc  = cm;
        push_rand(npush);
        cmd_header = h;
        cmd_arg    = a;
        cmd_len    = l;
        cmd_valid  = 1'b1;
        accept();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = n_done;
        n = 0;
        while (n_done == d0 && n < budget) begin
            @(posedge CLK);
            n++;
        end
        chk("done_seen", n_done - d0, 1);
    endtask

    task automatic wait_tx(input int k);
        int n;
        n = 0;
        while (ntx < k && n < 500) begin
            @(posedge CLK);
            n++;
        end
        chk("tx_ready_seen", ntx >= k, 1);
    endtask

    initial begin
        int viol;
        int d0;
        int l;
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_header = '0;
        cmd_arg    = '0;
        cmd_len    = '0;
        tx_hold    = 0;
        rnd_hold   = 0;
        want_ones  = 0;
        want_cyc   = 1;

        #12;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_word", rx_word, 0);
        chk("rst_rx_idx", rx_idx, 0);
        @(negedge CLK);
        resetn = 1'b1;
        #1 chk("rdy_before_first_clk", cmd_ready, 0);
        @(posedge CLK);
        #1 chk("rdy_after_first_clk", cmd_ready, 1);

        // header only
        run_cmd(8'h02, 8'h05, 0, 0, 1, 0);
        wait_done(2000);
        chk("t1_cs_low_76", last_low, 76);
        chk("t1_mosi_0205", slv_words[(slv_n - 1) % 1024], 16'h0205);
        chk("t1_rx0", rx_log[0], 0);
        chk("t1_no_tx_ready", ntx, 0);

        // one payload word
        tx_src[tx_wr % 256] = 16'hBEEF;
        tx_wr++;
        run_cmd(8'h03, 8'h07, 1, 0, 1, 0);
        wait_done(2000);
        chk("t2_cs_low_148", last_low, 148);
        chk("t2_mosi0", slv_words[(slv_n - 2) % 1024], 16'h0307);
        chk("t2_mosi1", slv_words[(slv_n - 1) % 1024], 16'hBEEF);
        chk("t2_rx1_echo", rx_log[1], 16'h0307);

        // payload withheld before word 2
        run_cmd(8'h04, 8'h09, 3, 0, 0, 1);
        wait_tx(1);
        repeat (80) @(posedge CLK);
        viol = 0;
        repeat (50) begin
            @(negedge CLK);
            if (sck !== 1'b0 || cs_n !== 1'b0 || tx_ready !== 1'b0) viol++;
        end
        chk("t3_stall_frozen", viol, 0);
        push_rand(2);
        wait_done(2000);
        chk("t3_tx_ready_total", ntx, 3);

        // miso stuck high
        run_cmd(8'hA5, 8'h3C, 2, 1, 1, 2);
        wait_done(2000);
        chk("t4_rx_ones", rx_log[2], 16'hFFFF);

        // reset mid word 1
        run_cmd(8'h06, 8'h01, 2, 0, 0, 2);
        wait_tx(1);
        repeat (20) @(posedge CLK);
        d0 = n_done;
        #3 resetn = 1'b0;
        #1;
        chk("t5_async_cs_n", cs_n, 1);
        chk("t5_async_sck", sck, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        #1 chk("t5_rdy_low", cmd_ready, 0);
        @(posedge CLK);
        #1 chk("t5_rdy_high", cmd_ready, 1);
        chk("t5_no_done", n_done - d0, 0);
        run_cmd(8'h07, 8'h02, 1, 0, 1, 1);
        wait_done(2000);
        chk("t5_clean_rx1", rx_log[1], 16'h0702);

        // cmd_valid held through a transfer with another header
        want_ones  = 0;
        want_cyc   = 1;
        cmd_header = 8'h11;
        cmd_arg    = 8'h20;
        cmd_len    = 0;
        cmd_valid  = 1'b1;
        accept();
        cmd_header = 8'h22;
        wait_done(2000);
        chk("t6_first_hdr", slv_words[(slv_n - 1) % 1024], 16'h1120);
        accept();
        cmd_valid = 1'b0;
        wait_done(2000);
        chk("t6_second_hdr", slv_words[(slv_n - 1) % 1024], 16'h2220);

        // random commands
        for (int t = 0; t < 15; t++) begin
            l = $urandom_range(0, 5);
            rnd_hold = ($urandom_range(0, 2) == 0);
            run_cmd(8'($urandom), 8'($urandom), LB'(l),
                    $urandom_range(0, 3) == 0, !rnd_hold, l);
            wait_done(4000);
            rnd_hold = 0;
        end

        repeat (5) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
